// File: rtl/snoop_responder.sv
// snoop_responder: per-processor snoop port on the shared 9-bit bus.
// Watches bus words, tracks MSI state for a 4-line direct-mapped tag array,
// and sources write-backs for Modified lines hit by remote requests.
// Optional build macro: SNOOP_STATS_EN adds the snoop_count hit counter.
//
// Write-back FSM states
//   state | meaning
//   IDLE  | busReq is zero, no write-back outstanding
//   DRIVE | busReq holds a write-back word until it is echoed on busIn
module snoop_responder #(
  parameter logic [1:0] NODE_ID = 2'd1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [8:0] busIn,
  output logic [8:0] busReq,
  input  logic       fill_valid,
  input  logic [3:0] fill_addr,
  input  logic [1:0] fill_state,
  output logic       snoop_hit,
  output logic       wb_busy,
  output logic       wb_overflow
`ifdef SNOOP_STATS_EN
  ,
  output logic [7:0] snoop_count
`endif
);

  localparam logic [2:0] OP_RD  = 3'b001;
  localparam logic [2:0] OP_WR  = 3'b010;
  localparam logic [2:0] OP_INV = 3'b011;
  localparam logic [2:0] OP_WB  = 3'b100;
  localparam logic [1:0] ST_I   = 2'b00;
  localparam logic [1:0] ST_S   = 2'b01;
  localparam logic [1:0] ST_M   = 2'b10;

  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} wb_state_t;

  wb_state_t  state, state_nxt;
  logic [8:0] bus_q;
  logic [1:0] tag_q [4];
  logic [1:0] st_q  [4];
  logic [8:0] req_nxt;
  logic       hold_full, hold_full_nxt;
  logic [8:0] hold_word, hold_word_nxt;
  logic       ovf_nxt;

  logic [2:0] op;
  logic [1:0] src;
  logic [1:0] idx;
  logic [1:0] tag;
  logic [1:0] cur_st;
  logic       new_msg;
  logic       op_ok;
  logic       hit;
  logic       wb_gen;
  logic [1:0] snoop_st_nxt;
  logic [8:0] wb_word;

  // Decode the bus word and evaluate the snoop against current (pre-fill) contents.
  always_comb begin
    op           = busIn[8:6];
    src          = busIn[5:4];
    idx          = busIn[1:0];
    tag          = busIn[3:2];
    cur_st       = st_q[idx];
    // A requester stalled waiting for grant repeats its word; only changes count.
    new_msg      = (busIn != bus_q) && (busIn != 9'd0);
    op_ok        = (op == OP_RD) || (op == OP_WR) || (op == OP_INV);
    hit          = new_msg && (src != NODE_ID) && op_ok && (tag_q[idx] == tag) &&
                   ((cur_st == ST_S) || (cur_st == ST_M));
    wb_gen       = hit && (cur_st == ST_M);
    snoop_st_nxt = (op == OP_RD) ? ST_S : ST_I;
    wb_word      = {OP_WB, NODE_ID, busIn[3:0]};
  end

  // Bus history register and registered hit pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_q     <= 9'd0;
      snoop_hit <= 1'b0;
    end else begin
      bus_q     <= busIn;
      snoop_hit <= hit;
    end
  end

  // Tag array: snoop update first, so a same-index fill overrides it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        tag_q[i] <= 2'b00;
        st_q[i]  <= ST_I;
      end
    end else begin
      if (hit) st_q[idx] <= snoop_st_nxt;
      if (fill_valid) begin
        tag_q[fill_addr[1:0]] <= fill_addr[3:2];
        st_q[fill_addr[1:0]]  <= fill_state;
      end
    end
  end

  // Write-back FSM next-state: drive, hold one spare, drop beyond that.
  always_comb begin
    state_nxt     = state;
    req_nxt       = busReq;
    hold_full_nxt = hold_full;
    hold_word_nxt = hold_word;
    ovf_nxt       = wb_overflow;
    case (state)
      IDLE: begin
        if (wb_gen) begin
          req_nxt   = wb_word;
          state_nxt = DRIVE;
        end
      end
      DRIVE: begin
        if (busIn == busReq) begin
          if (hold_full) begin
            req_nxt       = hold_word;
            hold_full_nxt = wb_gen;
            if (wb_gen) hold_word_nxt = wb_word;
          end else if (wb_gen) begin
            req_nxt = wb_word;
          end else begin
            req_nxt   = 9'd0;
            state_nxt = IDLE;
          end
        end else if (wb_gen) begin
          if (!hold_full) begin
            hold_full_nxt = 1'b1;
            hold_word_nxt = wb_word;
          end else begin
            ovf_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write-back FSM registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busReq      <= 9'd0;
      hold_full   <= 1'b0;
      hold_word   <= 9'd0;
      wb_overflow <= 1'b0;
    end else begin
      state       <= state_nxt;
      busReq      <= req_nxt;
      hold_full   <= hold_full_nxt;
      hold_word   <= hold_word_nxt;
      wb_overflow <= ovf_nxt;
    end
  end

  assign wb_busy = (busReq != 9'd0);

`ifdef SNOOP_STATS_EN
  // Saturating count of snoop hit pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                            snoop_count <= 8'd0;
    else if (snoop_hit && snoop_count != 8'hFF) snoop_count <= snoop_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Testbench for snoop_responder (NODE_ID = 1): per-cycle vector table plus a
// write-back word scoreboard, then an asynchronous reset during DRIVE.
module tb_snoop_responder;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [8:0] busIn;
  logic [8:0] busReq;
  logic       fill_valid;
  logic [3:0] fill_addr;
  logic [1:0] fill_state;
  logic       snoop_hit;
  logic       wb_busy;
  logic       wb_overflow;
`ifdef SNOOP_STATS_EN
  logic [7:0] snoop_count;
`endif

  snoop_responder #(.NODE_ID(2'd1)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .busIn(busIn),
    .busReq(busReq),
    .fill_valid(fill_valid),
    .fill_addr(fill_addr),
    .fill_state(fill_state),
    .snoop_hit(snoop_hit),
    .wb_busy(wb_busy),
    .wb_overflow(wb_overflow)
`ifdef SNOOP_STATS_EN
    ,
    .snoop_count(snoop_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       fv;
    logic [3:0] fa;
    logic [1:0] fs;
    logic [8:0] bus;
    logic       hit;
    logic [8:0] req;
    logic       ovf;
    logic [8:0] wb;
  } vec_t;

  vec_t       vecs[$];
  logic [8:0] sb[$];
  logic [8:0] prev_req;
  int         errors = 0;
  int         checks = 0;
  int         exp_hits = 0;

  localparam logic [1:0] I = 2'b00, S = 2'b01, M = 2'b10;
  localparam logic [8:0] WB6 = 9'b100_01_0110;
  localparam logic [8:0] WB4 = 9'b100_01_0100;
  localparam logic [8:0] WB1 = 9'b100_01_0001;

  function automatic logic [8:0] msg(input logic [2:0] op, input logic [1:0] src,
                                     input logic [3:0] addr);
    return {op, src, addr};
  endfunction

  task automatic add(input logic fv, input logic [3:0] fa, input logic [1:0] fs,
                     input logic [8:0] bus, input logic hit, input logic [8:0] req,
                     input logic ovf, input logic [8:0] wb);
    vec_t v;
    v.fv = fv; v.fa = fa; v.fs = fs; v.bus = bus;
    v.hit = hit; v.req = req; v.ovf = ovf; v.wb = wb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock; then compare any newly presented write-back word with the scoreboard.
  task automatic tick();
    @(posedge clock);
    #1;
    if (busReq != prev_req && busReq != 9'd0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got %h expected none", busReq);
      end else begin
        chk("wb_word", busReq, sb.pop_front());
      end
    end
    prev_req = busReq;
  endtask

  initial begin
    reset_n = 1'b0; busIn = 9'd0; fill_valid = 1'b0; fill_addr = 4'd0; fill_state = 2'd0;
    prev_req = 9'd0;

    // idle bus and remote requests to never-filled lines
    for (int i = 0; i < 10; i++) add(0, 0, I, 9'd0, 0, 0, 0, 0);
    add(0, 0, I, msg(3'b001, 2'd2, 4'h0), 0, 0, 0, 0);
    add(0, 0, I, msg(3'b001, 2'd2, 4'h5), 0, 0, 0, 0);
    add(0, 0, I, msg(3'b010, 2'd3, 4'hA), 0, 0, 0, 0);
    add(0, 0, I, msg(3'b011, 2'd2, 4'hF), 0, 0, 0, 0);
    add(0, 0, I, 9'd0, 0, 0, 0, 0);
    // M line hit by a remote read miss, then echoed
    add(1, 4'h6, M, 9'd0, 0, 0, 0, 0);
    add(0, 0, I, 9'b001_10_0110, 1, WB6, 0, WB6);
    add(0, 0, I, 9'd0, 0, WB6, 0, 0);
    add(0, 0, I, WB6, 0, 0, 0, 0);
    add(0, 0, I, 9'd0, 0, 0, 0, 0);
    add(0, 0, I, msg(3'b001, 2'd3, 4'h6), 1, 0, 0, 0);        // S stays S
    add(0, 0, I, 9'd0, 0, 0, 0, 0);
    add(0, 0, I, 9'b010_11_0110, 1, 0, 0, 0);                 // S -> I
    add(0, 0, I, 9'd0, 0, 0, 0, 0);
    // write miss on S line, tag mismatch first
    add(1, 4'h6, S, 9'd0, 0, 0, 0, 0);
    add(0, 0, I, msg(3'b010, 2'd2, 4'hA), 0, 0, 0, 0);
    add(0, 0, I, 9'b010_11_0110, 1, 0, 0, 0);
    add(0, 0, I, 9'd0, 0, 0, 0, 0);
    add(0, 0, I, msg(3'b001, 2'd2, 4'h6), 0, 0, 0, 0);        // now I
    add(0, 0, I, 9'd0, 0, 0, 0, 0);
    // same read miss held for 5 cycles
    add(1, 4'h6, M, 9'd0, 0, 0, 0, 0);
    add(0, 0, I, 9'b001_10_0110, 1, WB6, 0, WB6);
    for (int i = 0; i < 4; i++) add(0, 0, I, 9'b001_10_0110, 0, WB6, 0, 0);
    add(0, 0, I, WB6, 0, 0, 0, 0);
    add(0, 0, I, 9'd0, 0, 0, 0, 0);
    // three M lines, no echo: drive, hold, drop
    add(1, 4'h4, M, 9'd0, 0, 0, 0, 0);
    add(1, 4'h1, M, 9'd0, 0, 0, 0, 0);
    add(1, 4'hF, M, 9'd0, 0, 0, 0, 0);
    add(0, 0, I, msg(3'b010, 2'd2, 4'h4), 1, WB4, 0, WB4);
    add(0, 0, I, msg(3'b010, 2'd2, 4'h1), 1, WB4, 0, WB1);
    add(0, 0, I, msg(3'b010, 2'd3, 4'hF), 1, WB4, 1, 0);
    add(0, 0, I, 9'd0, 0, WB4, 1, 0);
    add(0, 0, I, WB4, 0, WB1, 1, 0);
    add(0, 0, I, 9'd0, 0, WB1, 1, 0);
    add(0, 0, I, WB1, 0, 0, 1, 0);
    add(0, 0, I, 9'd0, 0, 0, 1, 0);
    // own-source message ignored, line still M afterwards
    add(1, 4'h6, M, 9'd0, 0, 0, 1, 0);
    add(0, 0, I, 9'b010_01_0110, 0, 0, 1, 0);
    add(0, 0, I, 9'd0, 0, 0, 1, 0);
    add(0, 0, I, 9'b001_10_0110, 1, WB6, 1, WB6);
    add(0, 0, I, WB6, 0, 0, 1, 0);
    add(0, 0, I, 9'd0, 0, 0, 1, 0);
    // fill and invalidate same index: snoop sees S, fill value M is kept
    add(1, 4'h6, M, msg(3'b011, 2'd2, 4'h6), 1, 0, 1, 0);
    add(0, 0, I, 9'd0, 0, 0, 1, 0);
    add(0, 0, I, msg(3'b001, 2'd3, 4'h6), 1, WB6, 1, WB6);
    add(0, 0, I, WB6, 0, 0, 1, 0);
    add(0, 0, I, 9'd0, 0, 0, 1, 0);
    // non-snoop ops on a valid line
    add(0, 0, I, msg(3'b101, 2'd2, 4'h6), 0, 0, 1, 0);
    add(0, 0, I, msg(3'b100, 2'd2, 4'h6), 0, 0, 1, 0);
    add(0, 0, I, 9'd0, 0, 0, 1, 0);
    add(0, 0, I, 9'd0, 0, 0, 1, 0);

    // reset state
    @(posedge clock); #1;
    chk("rst_busReq", busReq, 9'd0);
    chk("rst_hit", {8'd0, snoop_hit}, 9'd0);
    chk("rst_busy", {8'd0, wb_busy}, 9'd0);
    chk("rst_ovf", {8'd0, wb_overflow}, 9'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      fill_valid = vecs[i].fv;
      fill_addr  = vecs[i].fa;
      fill_state = vecs[i].fs;
      busIn      = vecs[i].bus;
      if (vecs[i].wb != 9'd0) sb.push_back(vecs[i].wb);
      if (vecs[i].hit) exp_hits++;
      tick();
      chk($sformatf("v%0d_hit", i), {8'd0, snoop_hit}, {8'd0, vecs[i].hit});
      chk($sformatf("v%0d_req", i), busReq, vecs[i].req);
      chk($sformatf("v%0d_busy", i), {8'd0, wb_busy}, {8'd0, vecs[i].req != 9'd0});
      chk($sformatf("v%0d_ovf", i), {8'd0, wb_overflow}, {8'd0, vecs[i].ovf});
    end
    fill_valid = 1'b0;
`ifdef SNOOP_STATS_EN
    chk("snoop_count", {1'b0, snoop_count}, exp_hits[8:0]);
`endif

    // asynchronous reset while a write-back is being driven
    fill_valid = 1'b1; fill_addr = 4'h6; fill_state = M; busIn = 9'd0;
    tick();
    fill_valid = 1'b0; busIn = 9'b001_10_0110; sb.push_back(WB6);
    tick();
    chk("ar_pre_req", busReq, WB6);
    busIn = 9'd0;
    tick();
    #2 reset_n = 1'b0;
    #1;
    chk("ar_req", busReq, 9'd0);
    chk("ar_busy", {8'd0, wb_busy}, 9'd0);
    chk("ar_ovf", {8'd0, wb_overflow}, 9'd0);
`ifdef SNOOP_STATS_EN
    chk("ar_count", {1'b0, snoop_count}, 9'd0);
`endif
    #1 reset_n = 1'b1;
    prev_req = busReq;
    tick();
    chk("ar_post_req", busReq, 9'd0);
    busIn = 9'b001_10_0110;
    tick();
    chk("ar_line_cleared_hit", {8'd0, snoop_hit}, 9'd0);
    chk("ar_line_cleared_req", busReq, 9'd0);
    busIn = 9'd0;
    tick();
    chk("sb_empty", sb.size() > 0 ? 9'd1 : 9'd0, 9'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
